// File: rtl/cv32e40x_pkg.sv
// Shared types for the write-back stage: EX/WB pipeline contents, CSR opcodes,
// WB FSM states and the LSU response buffer entry.
package cv32e40x_pkg;

  localparam int WB_RESP_BUF_DEPTH_MAX = 2;

  typedef logic [4:0] rf_addr_t;

  typedef enum logic [1:0] {
    CSR_OP_READ,
    CSR_OP_WRITE,
    CSR_OP_SET,
    CSR_OP_CLEAR
  } csr_opcode_e;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ACTIVE,
    WB_WAIT,
    WB_DRAIN
  } wb_state_e;

  typedef struct packed {
    logic        instr_valid;
    logic [31:0] pc;
    logic        rf_we;
    rf_addr_t    rf_waddr;
    logic [31:0] rf_wdata;
    logic        data_req;
    logic        csr_en;
    logic        csr_access;
    csr_opcode_e csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        illegal_insn;
    logic        ecall_insn;
    logic        ebrk_insn;
  } ex_wb_pipe_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } wb_resp_t;

endpackage

// File: rtl/cv32e40x_wb_resp_buf.sv
// Small FIFO of LSU responses ({rdata, err}) that arrive while WB cannot consume them.
// A push into a full buffer is ignored unless a pop frees the slot in the same cycle.
module cv32e40x_wb_resp_buf
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  wb_resp_t wdata,
  output logic     empty,
  output logic     full,
  output wb_resp_t head
);

  wb_resp_t   mem [WB_RESP_BUF_DEPTH_MAX];
  logic       rptr;
  logic       wptr;
  logic [1:0] cnt;
  logic       wr_en;
  logic       rd_en;

  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'(DEPTH));
  assign head  = mem[rptr];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (wr_en) wptr <= (wptr == 1'(DEPTH - 1)) ? 1'b0 : ~wptr;
      if (rd_en) rptr <= (rptr == 1'(DEPTH - 1)) ? 1'b0 : ~rptr;
      cnt <= cnt + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  // Payload storage carries no reset; only pointers and count are control state.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cv32e40x_wb_stage.sv
// Write-back stage: retires the EX/WB instruction, completes LSU accesses against
// the data response, drives RF/CSR writes and counts retired instructions.
module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int RESP_BUF_DEPTH = 1,
  parameter int INSTRET_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  ex_wb_pipe_t          ex_wb_pipe_i,
  input  logic                 halt_wb_i,
  input  logic                 kill_wb_i,
  input  logic                 lsu_rvalid_i,
  input  logic [31:0]          lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 rf_we_wb_o,
  output rf_addr_t             rf_waddr_wb_o,
  output logic [31:0]          rf_wdata_wb_o,
  output logic                 csr_we_o,
  output csr_opcode_e          csr_op_o,
  output logic [11:0]          csr_addr_o,
  output logic [31:0]          csr_wdata_o,
  output logic                 lsu_exc_o,
  output logic [31:0]          lsu_exc_pc_o,
  output logic                 wb_valid_o,
  output logic                 wb_ready_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 resp_ovf_o
);

  wb_state_e            state_q;
  wb_state_e            state_d;
  wb_state_e            state;
  wb_resp_t             buf_head;
  wb_resp_t             resp;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_push;
  logic                 buf_pop;
  logic                 buf_flush;
  logic                 instr_valid;
  logic                 dreq;
  logic                 resp_avail;
  logic                 complete;
  logic                 active;
  logic                 lsu_err;
  logic                 instr_exc;
  logic [INSTRET_W-1:0] instret_q;
  logic                 resp_ovf_q;

  assign instr_valid = ex_wb_pipe_i.instr_valid;
  assign dreq        = instr_valid && ex_wb_pipe_i.data_req;
  assign resp_avail  = lsu_rvalid_i || !buf_empty;
  // Buffered responses are older than the live one, so the head always wins.
  assign resp        = buf_empty ? wb_resp_t'({lsu_rdata_i, lsu_err_i}) : buf_head;

  // Current state is classified from this cycle's inputs so that a ready
  // instruction completes with zero latency; only DRAIN persists across cycles.
  always_comb begin
    state   = WB_IDLE;
    state_d = WB_IDLE;
    if (state_q == WB_DRAIN)            state = WB_DRAIN;
    else if (!instr_valid)              state = WB_IDLE;
    else if (dreq && !resp_avail)       state = WB_WAIT;
    else                                state = WB_ACTIVE;
    unique case (state)
      WB_DRAIN: state_d = lsu_rvalid_i ? WB_IDLE : WB_DRAIN;
      WB_WAIT:  state_d = kill_wb_i ? WB_DRAIN : WB_WAIT;
      default:  state_d = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WB_IDLE;
    else     state_q <= state_d;
  end

  assign complete  = instr_valid &&
                     ((!halt_wb_i && (!ex_wb_pipe_i.data_req || resp_avail)) || kill_wb_i);
  assign active    = (state == WB_ACTIVE) || (state == WB_WAIT);
  assign lsu_err   = dreq && resp.err;
  assign instr_exc = ex_wb_pipe_i.illegal_insn || ex_wb_pipe_i.ecall_insn ||
                     ex_wb_pipe_i.ebrk_insn;

  assign wb_valid_o    = complete && active;
  assign wb_ready_o    = (!instr_valid || wb_valid_o) && (state != WB_DRAIN);
  assign rf_we_wb_o    = wb_valid_o && ex_wb_pipe_i.rf_we && !kill_wb_i && !lsu_err && !instr_exc;
  assign rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr;
  assign rf_wdata_wb_o = ex_wb_pipe_i.data_req ? resp.rdata : ex_wb_pipe_i.rf_wdata;
  assign csr_we_o      = wb_valid_o && ex_wb_pipe_i.csr_en && ex_wb_pipe_i.csr_access &&
                         !kill_wb_i && (ex_wb_pipe_i.csr_op != CSR_OP_READ);
  assign csr_op_o      = ex_wb_pipe_i.csr_op;
  assign csr_addr_o    = ex_wb_pipe_i.csr_addr;
  assign csr_wdata_o   = ex_wb_pipe_i.csr_wdata;
  assign lsu_exc_o     = wb_valid_o && lsu_err && !kill_wb_i;
  assign lsu_exc_pc_o  = ex_wb_pipe_i.pc;

  // Responses with no waiting load (after reset, or while draining) are dropped.
  assign buf_push  = lsu_rvalid_i && dreq && (state != WB_DRAIN) &&
                     !(wb_valid_o && buf_empty);
  assign buf_pop   = wb_valid_o && dreq && !kill_wb_i;
  assign buf_flush = wb_valid_o && dreq && kill_wb_i;

  cv32e40x_wb_resp_buf #(
    .DEPTH (RESP_BUF_DEPTH)
  ) u_resp_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (buf_flush),
    .wdata (wb_resp_t'({lsu_rdata_i, lsu_err_i})),
    .empty (buf_empty),
    .full  (buf_full),
    .head  (buf_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q  <= '0;
      resp_ovf_q <= 1'b0;
    end else begin
      if (wb_valid_o && !kill_wb_i && !lsu_exc_o) instret_q <= instret_q + INSTRET_W'(1);
      if (buf_push && buf_full && !buf_pop && !buf_flush) resp_ovf_q <= 1'b1;
    end
  end

  assign instret_o  = instret_q;
  assign resp_ovf_o = resp_ovf_q;

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
// Scoreboard bench for cv32e40x_wb_stage: expected retirements are queued when an
// instruction is driven and compared whenever the stage reports wb_valid_o.
module tb_cv32e40x_wb_stage;
  import cv32e40x_pkg::*;

  localparam int INSTRET_W = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  ex_wb_pipe_t          pipe;
  logic                 halt;
  logic                 kill;
  logic                 rvalid;
  logic [31:0]          rdata;
  logic                 err;
  logic                 rf_we_wb_o;
  rf_addr_t             rf_waddr_wb_o;
  logic [31:0]          rf_wdata_wb_o;
  logic                 csr_we_o;
  csr_opcode_e          csr_op_o;
  logic [11:0]          csr_addr_o;
  logic [31:0]          csr_wdata_o;
  logic                 lsu_exc_o;
  logic [31:0]          lsu_exc_pc_o;
  logic                 wb_valid_o;
  logic                 wb_ready_o;
  logic [INSTRET_W-1:0] instret_o;
  logic                 resp_ovf_o;

  always #5 clk = ~clk;

  cv32e40x_wb_stage #(
    .RESP_BUF_DEPTH (1),
    .INSTRET_W      (INSTRET_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_wb_pipe_i  (pipe),
    .halt_wb_i     (halt),
    .kill_wb_i     (kill),
    .lsu_rvalid_i  (rvalid),
    .lsu_rdata_i   (rdata),
    .lsu_err_i     (err),
    .rf_we_wb_o    (rf_we_wb_o),
    .rf_waddr_wb_o (rf_waddr_wb_o),
    .rf_wdata_wb_o (rf_wdata_wb_o),
    .csr_we_o      (csr_we_o),
    .csr_op_o      (csr_op_o),
    .csr_addr_o    (csr_addr_o),
    .csr_wdata_o   (csr_wdata_o),
    .lsu_exc_o     (lsu_exc_o),
    .lsu_exc_pc_o  (lsu_exc_pc_o),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_o    (wb_ready_o),
    .instret_o     (instret_o),
    .resp_ovf_o    (resp_ovf_o)
  );

  typedef struct {
    logic        we;
    rf_addr_t    waddr;
    logic [31:0] wdata;
    logic        csr_we;
    logic        exc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe   = '0;
    halt   = 1'b0;
    kill   = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    err    = 1'b0;
  endtask

  function automatic ex_wb_pipe_t mk_alu(input rf_addr_t a, input logic [31:0] d);
    ex_wb_pipe_t p;
    p             = '0;
    p.instr_valid = 1'b1;
    p.rf_we       = 1'b1;
    p.rf_waddr    = a;
    p.rf_wdata    = d;
    return p;
  endfunction

  function automatic ex_wb_pipe_t mk_load(input rf_addr_t a, input logic [31:0] pc);
    ex_wb_pipe_t p;
    p             = '0;
    p.instr_valid = 1'b1;
    p.rf_we       = 1'b1;
    p.rf_waddr    = a;
    p.rf_wdata    = 32'h0BAD_0BAD;
    p.data_req    = 1'b1;
    p.pc          = pc;
    return p;
  endfunction

  function automatic exp_t mk_exp(input logic we, input rf_addr_t a, input logic [31:0] d,
                                  input logic csr, input logic exc, input logic [31:0] pc);
    exp_t e;
    e.we     = we;
    e.waddr  = a;
    e.wdata  = d;
    e.csr_we = csr;
    e.exc    = exc;
    e.pc     = pc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && wb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_retire", 64'(wb_valid_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rf_we", 64'(rf_we_wb_o), 64'(mon_e.we));
        if (mon_e.we) begin
          chk("rf_waddr", 64'(rf_waddr_wb_o), 64'(mon_e.waddr));
          chk("rf_wdata", 64'(rf_wdata_wb_o), 64'(mon_e.wdata));
        end
        chk("csr_we", 64'(csr_we_o), 64'(mon_e.csr_we));
        chk("lsu_exc", 64'(lsu_exc_o), 64'(mon_e.exc));
        if (mon_e.exc) chk("lsu_exc_pc", 64'(lsu_exc_pc_o), 64'(mon_e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_ovf", 64'(resp_ovf_o), 64'd0);
    chk("rst_ready", 64'(wb_ready_o), 64'd1);
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_state", 64'(dut.state), 64'(WB_IDLE));

    // ALU op retires in the cycle it is presented.
    tick();
    pipe = mk_alu(5'd5, 32'h1234);
    sb.push_back(mk_exp(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("alu_ready", 64'(wb_ready_o), 64'd1);
    chk("alu_valid", 64'(wb_valid_o), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("alu_instret", instret_o, 64'd1);

    // Load whose response arrives three cycles late.
    tick();
    pipe = mk_load(5'd7, 32'h40);
    sb.push_back(mk_exp(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("ld_wait_ready", 64'(wb_ready_o), 64'd0);
      chk("ld_wait_valid", 64'(wb_valid_o), 64'd0);
      chk("ld_wait_state", 64'(dut.state), 64'(WB_WAIT));
    end
    tick();
    rvalid = 1'b1;
    rdata  = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_resp_valid", 64'(wb_valid_o), 64'd1);
    chk("ld_resp_ready", 64'(wb_ready_o), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("ld_instret", instret_o, 64'd2);

    // Response arrives while halted and is held in the buffer.
    tick();
    pipe   = mk_load(5'd8, 32'h44);
    halt   = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'hCAFEF00D;
    sb.push_back(mk_exp(1'b1, 5'd8, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("halt_valid", 64'(wb_valid_o), 64'd0);
    tick();
    rvalid = 1'b0;
    rdata  = 32'h0;
    @(negedge clk);
    chk("halt_buf_empty", 64'(dut.buf_empty), 64'd0);
    chk("halt_ready", 64'(wb_ready_o), 64'd0);
    tick();
    halt = 1'b0;
    @(negedge clk);
    chk("halt_rel_valid", 64'(wb_valid_o), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("halt_buf_drained", 64'(dut.buf_empty), 64'd1);
    chk("halt_instret", instret_o, 64'd3);

    // Kill while waiting: the later response must be discarded.
    tick();
    pipe = mk_load(5'd9, 32'h48);
    @(negedge clk);
    chk("kill_pre_ready", 64'(wb_ready_o), 64'd0);
    tick();
    kill = 1'b1;
    sb.push_back(mk_exp(1'b0, 5'd9, 32'h0, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("kill_valid", 64'(wb_valid_o), 64'd1);
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("drain_ready", 64'(wb_ready_o), 64'd0);
      chk("drain_state", 64'(dut.state), 64'(WB_DRAIN));
    end
    tick();
    rvalid = 1'b1;
    rdata  = 32'hAAAA5555;
    @(negedge clk);
    chk("drain_rf_we", 64'(rf_we_wb_o), 64'd0);
    chk("drain_resp_ready", 64'(wb_ready_o), 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("drain_exit_state", 64'(dut.state), 64'(WB_IDLE));
    chk("drain_exit_ready", 64'(wb_ready_o), 64'd1);
    chk("drain_exit_buf", 64'(dut.buf_empty), 64'd1);
    chk("kill_instret", instret_o, 64'd3);

    // Bus error on a load.
    tick();
    pipe   = mk_load(5'd10, 32'h80);
    rvalid = 1'b1;
    rdata  = 32'h0000005A;
    err    = 1'b1;
    sb.push_back(mk_exp(1'b0, 5'd10, 32'h0, 1'b0, 1'b1, 32'h80));
    @(negedge clk);
    chk("err_exc", 64'(lsu_exc_o), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("err_exc_pulse", 64'(lsu_exc_o), 64'd0);
    chk("err_instret", instret_o, 64'd3);

    // Counter wrap from all-ones, with a CSR write and a CSR read.
    force dut.instret_q = {INSTRET_W{1'b1}};
    #1;
    release dut.instret_q;
    chk("wrap_preload", instret_o, {INSTRET_W{1'b1}});
    tick();
    pipe            = mk_alu(5'd11, 32'h11);
    pipe.csr_en     = 1'b1;
    pipe.csr_access = 1'b1;
    pipe.csr_op     = CSR_OP_WRITE;
    pipe.csr_addr   = 12'h300;
    sb.push_back(mk_exp(1'b1, 5'd11, 32'h11, 1'b1, 1'b0, 32'h0));
    @(negedge clk);
    chk("csr_addr", 64'(csr_addr_o), 64'h300);
    tick();
    pipe            = mk_alu(5'd12, 32'h22);
    pipe.csr_en     = 1'b1;
    pipe.csr_access = 1'b1;
    pipe.csr_op     = CSR_OP_READ;
    sb.push_back(mk_exp(1'b1, 5'd12, 32'h22, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("wrap_instret0", instret_o, 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("wrap_instret1", instret_o, 64'd1);

    // Two responses while halted overflow a one-entry buffer.
    tick();
    pipe   = mk_load(5'd13, 32'h90);
    halt   = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'h1111;
    sb.push_back(mk_exp(1'b1, 5'd13, 32'h1111, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("ovf_first", 64'(resp_ovf_o), 64'd0);
    tick();
    rdata = 32'h2222;
    @(negedge clk);
    tick();
    rvalid = 1'b0;
    halt   = 1'b0;
    @(negedge clk);
    chk("ovf_set", 64'(resp_ovf_o), 64'd1);
    chk("ovf_retire", 64'(wb_valid_o), 64'd1);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("ovf_sticky", 64'(resp_ovf_o), 64'd1);
    end

    // Reset in the middle of a wait; a late response is dropped.
    tick();
    pipe = mk_load(5'd14, 32'hA0);
    @(negedge clk);
    chk("rstw_state", 64'(dut.state), 64'(WB_WAIT));
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hBBBB;
    @(negedge clk);
    chk("rstw_valid", 64'(wb_valid_o), 64'd0);
    chk("rstw_rf_we", 64'(rf_we_wb_o), 64'd0);
    tick();
    rvalid = 1'b0;
    @(negedge clk);
    chk("rstw_buf", 64'(dut.buf_empty), 64'd1);
    chk("rstw_state_idle", 64'(dut.state), 64'(WB_IDLE));
    chk("rstw_ovf", 64'(resp_ovf_o), 64'd0);
    chk("rstw_instret", instret_o, 64'd0);

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
